// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl -- issue and HI/LO control for the M1 multiply/divide path.
//
// Accepts MULT/MULTU/DIV/DIVU/MFHI/MFLO/MTHI/MTLO from execute, launches the
// iterative multiplier or divider over a toggle-level (ABP) handshake, and
// captures the unit result into the architectural HI/LO registers. While a
// unit is in flight every incoming op is stalled.
//
// Ports:
//   sys_clock_i, sys_reset_i    clock, synchronous active-high reset
//   op_valid_i, op_i, a_i, b_i  execute-stage op strobe, opcode, rs/rt
//   stall_o                     op not accepted this cycle (combinational)
//   result_o, result_valid_o    MFHI/MFLO read data and its strobe
//   busy_o                      a unit is in flight
//   hi_o, lo_o                  architectural HI/LO
//   opnd_a_o, opnd_b_o,
//   opnd_signed_o               registered operands shared by both units
//   mul_req_o / mul_ack_i       multiplier request / acknowledge levels
//   mul_product_i               64-bit product
//   div_req_o / div_ack_i       divider request / acknowledge levels
//   div_quotient_i,
//   div_remainder_i             divider results
module muldiv_ctrl #(
  parameter bit DIV0_BYPASS = 1'b1
) (
  input  logic        sys_clock_i,
  input  logic        sys_reset_i,
  input  logic        op_valid_i,
  input  logic [2:0]  op_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic        stall_o,
  output logic [31:0] result_o,
  output logic        result_valid_o,
  output logic        busy_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic [31:0] opnd_a_o,
  output logic [31:0] opnd_b_o,
  output logic        opnd_signed_o,
  output logic        mul_req_o,
  input  logic        mul_ack_i,
  input  logic [63:0] mul_product_i,
  output logic        div_req_o,
  input  logic        div_ack_i,
  input  logic [31:0] div_quotient_i,
  input  logic [31:0] div_remainder_i
);

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MFHI  = 3'b100;
  localparam logic [2:0] OP_MFLO  = 3'b101;
  localparam logic [2:0] OP_MTHI  = 3'b110;
  localparam logic [2:0] OP_MTLO  = 3'b111;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MUL_WAIT = 2'd1,
    DIV_WAIT = 2'd2
  } state_t;

  state_t state_r;
  logic   accept_s;
  logic   is_mf_s;

  // Issue-side decode: stall, accept and the MFHI/MFLO read port.
  always_comb begin
    busy_o         = (state_r != IDLE);
    stall_o        = op_valid_i & busy_o;
    accept_s       = op_valid_i & ~busy_o;
    is_mf_s        = (op_i == OP_MFHI) | (op_i == OP_MFLO);
    result_valid_o = accept_s & is_mf_s;
    // op_i[0] selects LO for MFLO, HI for MFHI.
    if (op_i[0]) begin
      result_o = lo_o;
    end else begin
      result_o = hi_o;
    end
  end

  // Control FSM with HI/LO, operand and request-level registers.
  always_ff @(posedge sys_clock_i) begin
    if (sys_reset_i) begin
      state_r       <= IDLE;
      hi_o          <= 32'd0;
      lo_o          <= 32'd0;
      opnd_a_o      <= 32'd0;
      opnd_b_o      <= 32'd0;
      opnd_signed_o <= 1'b0;
      mul_req_o     <= 1'b0;
      div_req_o     <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            case (op_i)
              OP_MULT, OP_MULTU: begin
                opnd_a_o      <= a_i;
                opnd_b_o      <= b_i;
                opnd_signed_o <= (op_i == OP_MULT);
                mul_req_o     <= ~mul_req_o;
                state_r       <= MUL_WAIT;
              end
              OP_DIV, OP_DIVU: begin
                if (DIV0_BYPASS && (b_i == 32'd0)) begin
                  // Divide by zero never reaches the divider.
                  hi_o <= a_i;
                  lo_o <= 32'hFFFF_FFFF;
                end else begin
                  opnd_a_o      <= a_i;
                  opnd_b_o      <= b_i;
                  opnd_signed_o <= (op_i == OP_DIV);
                  div_req_o     <= ~div_req_o;
                  state_r       <= DIV_WAIT;
                end
              end
              OP_MTHI: hi_o <= a_i;
              OP_MTLO: lo_o <= a_i;
              default: begin
                // MFHI/MFLO are served combinationally; no state change.
              end
            endcase
          end
        end
        MUL_WAIT: begin
          // Completion is the level match, independent of unit latency.
          if (mul_ack_i == mul_req_o) begin
            hi_o    <= mul_product_i[63:32];
            lo_o    <= mul_product_i[31:0];
            state_r <= IDLE;
          end
        end
        DIV_WAIT: begin
          if (div_ack_i == div_req_o) begin
            hi_o    <= div_remainder_i;
            lo_o    <= div_quotient_i;
            state_r <= IDLE;
          end
        end
        default: state_r <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Bench for muldiv_ctrl: toggle-handshake multiplier/divider models with a
// selectable latency, a cycle-level behavioural model of HI/LO and busy
// timing, directed scenarios with literal expectations, then random traffic.
module tb_muldiv_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        op_valid;
  logic [2:0]  op;
  logic [31:0] a, b;
  logic        stall, result_valid, busy, opnd_signed, mul_req, div_req;
  logic [31:0] result, hi, lo, opnd_a, opnd_b;
  logic        mul_ack, div_ack;
  logic [63:0] mul_product;
  logic [31:0] div_q, div_r;

  int vectors = 0;
  int miscompares = 0;
  logic chk_en = 1'b0;

  always #5 clk = ~clk;

  muldiv_ctrl #(.DIV0_BYPASS(1'b1)) dut (
    .sys_clock_i(clk), .sys_reset_i(rst), .op_valid_i(op_valid), .op_i(op),
    .a_i(a), .b_i(b), .stall_o(stall), .result_o(result),
    .result_valid_o(result_valid), .busy_o(busy), .hi_o(hi), .lo_o(lo),
    .opnd_a_o(opnd_a), .opnd_b_o(opnd_b), .opnd_signed_o(opnd_signed),
    .mul_req_o(mul_req), .mul_ack_i(mul_ack), .mul_product_i(mul_product),
    .div_req_o(div_req), .div_ack_i(div_ack), .div_quotient_i(div_q),
    .div_remainder_i(div_r)
  );

  // ---------------- unit models ----------------
  int   cur_lat = 33;      // latency of the op now in flight, set by the model
  logic m_seen, m_run, d_seen, d_run;
  int   m_cnt, d_cnt;

  always @(posedge clk) begin
    if (rst) begin
      mul_ack <= 1'b0; m_seen <= 1'b0; m_run <= 1'b0; m_cnt <= 0;
      mul_product <= 64'd0;
    end else if (mul_req !== m_seen) begin
      m_seen <= mul_req; m_run <= 1'b1; m_cnt <= cur_lat;
      if (opnd_signed)
        mul_product <= {{32{opnd_a[31]}}, opnd_a} * {{32{opnd_b[31]}}, opnd_b};
      else
        mul_product <= {32'd0, opnd_a} * {32'd0, opnd_b};
    end else if (m_run) begin
      if (m_cnt <= 1) begin
        mul_ack <= ~mul_ack; m_run <= 1'b0;
      end
      m_cnt <= m_cnt - 1;
    end
  end

  always @(posedge clk) begin
    if (rst) begin
      div_ack <= 1'b0; d_seen <= 1'b0; d_run <= 1'b0; d_cnt <= 0;
      div_q <= 32'd0; div_r <= 32'd0;
    end else if (div_req !== d_seen) begin
      d_seen <= div_req; d_run <= 1'b1; d_cnt <= cur_lat;
      if (opnd_signed) begin
        div_q <= $signed(opnd_a) / $signed(opnd_b);
        div_r <= $signed(opnd_a) % $signed(opnd_b);
      end else begin
        div_q <= opnd_a / opnd_b;
        div_r <= opnd_a % opnd_b;
      end
    end else if (d_run) begin
      if (d_cnt <= 1) begin
        div_ack <= ~div_ack; d_run <= 1'b0;
      end
      d_cnt <= d_cnt - 1;
    end
  end

  // ---------------- behavioural model ----------------
  // Busy lasts lat+2 edges after the accept edge (unit latches one edge
  // later, acks lat edges after that, capture on the edge after the ack).
  logic [31:0] e_hi = 32'd0, e_lo = 32'd0, e_opa = 32'd0, e_opb = 32'd0;
  logic [31:0] e_rhi = 32'd0, e_rlo = 32'd0;
  logic        e_sgn = 1'b0, e_mreq = 1'b0, e_dreq = 1'b0, e_busy = 1'b0;
  int          e_cnt = 0;
  int          lat_sel = 33;

  task automatic model_step();
    longint p;
    int sa, sb;
    if (rst) begin
      e_hi = 32'd0; e_lo = 32'd0; e_opa = 32'd0; e_opb = 32'd0; e_sgn = 1'b0;
      e_mreq = 1'b0; e_dreq = 1'b0; e_busy = 1'b0; e_cnt = 0;
    end else if (e_busy) begin
      e_cnt = e_cnt - 1;
      if (e_cnt == 0) begin
        e_hi = e_rhi; e_lo = e_rlo; e_busy = 1'b0;
      end
    end else if (op_valid) begin
      if (op == 3'd0 || op == 3'd1) begin
        e_opa = a; e_opb = b; e_sgn = (op == 3'd0);
        if (e_sgn) p = longint'($signed(a)) * longint'($signed(b));
        else       p = longint'({32'd0, a}) * longint'({32'd0, b});
        e_rhi = p[63:32]; e_rlo = p[31:0];
        e_mreq = ~e_mreq; e_busy = 1'b1; e_cnt = lat_sel + 2; cur_lat = lat_sel;
      end else if (op == 3'd2 || op == 3'd3) begin
        if (b == 32'd0) begin
          e_hi = a; e_lo = 32'hFFFF_FFFF;
        end else begin
          e_opa = a; e_opb = b; e_sgn = (op == 3'd2);
          sa = a; sb = b;
          if (e_sgn) begin e_rlo = sa / sb; e_rhi = sa % sb; end
          else       begin e_rlo = a / b;   e_rhi = a % b;   end
          e_dreq = ~e_dreq; e_busy = 1'b1; e_cnt = lat_sel + 2; cur_lat = lat_sel;
        end
      end else if (op == 3'd6) begin
        e_hi = a;
      end else if (op == 3'd7) begin
        e_lo = a;
      end
    end
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp_v);
    if (act !== exp_v) begin
      miscompares++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp_v, $time);
    end
  endtask

  // Compare process: checks every cycle, then advances the model over the next edge.
  always @(negedge clk) begin
    logic mf;
    #2;
    if (chk_en) begin
      vectors++;
      mf = op_valid & ~e_busy & (op == 3'd4 || op == 3'd5);
      chk("busy", busy, e_busy);
      chk("stall", stall, op_valid & e_busy);
      chk("result_valid", result_valid, mf);
      if (mf) chk("result", result, op[0] ? e_lo : e_hi);
      chk("hi", hi, e_hi);
      chk("lo", lo, e_lo);
      chk("mul_req", mul_req, e_mreq);
      chk("div_req", div_req, e_dreq);
      chk("opnd_a", opnd_a, e_opa);
      chk("opnd_b", opnd_b, e_opb);
      chk("opnd_signed", opnd_signed, e_sgn);
    end
    model_step();
  end

  // ---------------- stimulus helpers ----------------
  task automatic drive(input logic v, input logic [2:0] o, input logic [31:0] aa, input logic [31:0] bb);
    @(negedge clk);
    rst = 1'b0; op_valid = v; op = o; a = aa; b = bb;
  endtask

  task automatic idle();
    drive(1'b0, 3'($urandom), $urandom, $urandom);
  endtask

  task automatic reset_cycle();
    @(negedge clk);
    rst = 1'b1; op_valid = 1'b0;
  endtask

  // Hold an op until it is accepted; returns in its accept cycle.
  task automatic issue(input logic [2:0] o, input logic [31:0] aa, input logic [31:0] bb, input int lat);
    int n = 0;
    lat_sel = lat;
    drive(1'b1, o, aa, bb); #1;
    while (e_busy && n < 200) begin
      drive(1'b1, o, aa, bb); #1; n++;
    end
    if (e_busy) chk("issue_timeout", 64'd1, 64'd0);
  endtask

  // Idle until the model says the unit is done; returns in the first free cycle.
  task automatic wait_done();
    int n = 0;
    idle(); #1;
    while (e_busy && n < 200) begin
      idle(); #1; n++;
    end
    if (e_busy) chk("done_timeout", 64'd1, 64'd0);
  endtask

  initial begin
    int n;
    rst = 1'b1; op_valid = 1'b0; op = 3'd0; a = 32'd0; b = 32'd0;
    @(posedge clk);
    chk_en = 1'b1;
    reset_cycle();
    idle(); #1;
    chk("rst_hi", hi, 64'd0); chk("rst_lo", lo, 64'd0); chk("rst_busy", busy, 64'd0);
    chk("rst_mul_req", mul_req, 64'd0); chk("rst_div_req", div_req, 64'd0);

    // MULTU 17*3 with the nominal 33-edge unit: capture at N+35.
    issue(3'd1, 32'd17, 32'd3, 33);
    idle(); #1;
    chk("multu_req", mul_req, 64'd1); chk("multu_div_req", div_req, 64'd0);
    chk("multu_opa", opnd_a, 64'd17); chk("multu_busy", busy, 64'd1);
    repeat (34) idle();
    #1 chk("multu_busy_n34", busy, 64'd1);
    idle(); #1;
    chk("multu_busy_n35", busy, 64'd0);
    chk("multu_hi", hi, 64'd0); chk("multu_lo", lo, 64'd51);
    chk("model_lo_51", e_lo, 64'd51);

    // MULT -7*3 signed, odd latency.
    issue(3'd0, 32'hFFFF_FFF9, 32'd3, 7);
    idle(); #1 chk("mult_signed", opnd_signed, 64'd1);
    wait_done();
    chk("mult_hi", hi, 64'hFFFF_FFFF); chk("mult_lo", lo, 64'hFFFF_FFEB);
    chk("mult_req_back", mul_req, 64'd0);

    // DIVU 17/5 then DIV 20/4.
    issue(3'd3, 32'd17, 32'd5, 33);
    wait_done();
    chk("divu_lo", lo, 64'd3); chk("divu_hi", hi, 64'd2); chk("divu_req", div_req, 64'd1);
    issue(3'd2, 32'd20, 32'd4, 12);
    wait_done();
    chk("div_lo", lo, 64'd5); chk("div_hi", hi, 64'd0); chk("div_req", div_req, 64'd0);

    // MFLO held behind DIVU 17/5: 35 stalled cycles, then one read.
    issue(3'd3, 32'd17, 32'd5, 33);
    n = 0;
    drive(1'b1, 3'd5, 32'd0, 32'd0); #1;
    while (e_busy && n < 100) begin
      chk("mflo_stall", stall, 64'd1);
      n++;
      drive(1'b1, 3'd5, 32'd0, 32'd0); #1;
    end
    chk("mflo_stall_cycles", 64'(n), 64'd35);
    chk("mflo_valid", result_valid, 64'd1); chk("mflo_result", result, 64'd3);
    chk("mflo_stall_end", stall, 64'd0);
    idle(); #1 chk("mflo_valid_once", result_valid, 64'd0);

    // DIVU 9/0 bypass: no request, never busy.
    issue(3'd3, 32'd9, 32'd0, 33);
    idle(); #1;
    chk("div0_hi", hi, 64'd9); chk("div0_lo", lo, 64'hFFFF_FFFF);
    chk("div0_busy", busy, 64'd0); chk("div0_req", div_req, 64'd1);

    // Reset in the middle of a multiply.
    issue(3'd1, 32'd100, 32'd200, 33);
    repeat (10) idle();
    reset_cycle();
    idle(); #1;
    chk("mrst_busy", busy, 64'd0); chk("mrst_hi", hi, 64'd0); chk("mrst_lo", lo, 64'd0);
    chk("mrst_mul_req", mul_req, 64'd0); chk("mrst_div_req", div_req, 64'd0);
    chk("mrst_opa", opnd_a, 64'd0); chk("mrst_sgn", opnd_signed, 64'd0);
    issue(3'd6, 32'h1234, 32'd0, 33);
    drive(1'b1, 3'd4, 32'd0, 32'd0); #1;
    chk("mfhi_valid", result_valid, 64'd1); chk("mfhi_result", result, 64'h1234);
    issue(3'd1, 32'd6, 32'd7, 33);
    repeat (35) idle();
    #1 chk("m42_busy_n34", busy, 64'd1);
    idle(); #1;
    chk("m42_busy", busy, 64'd0); chk("m42_lo", lo, 64'd42);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      logic [2:0]  ro;
      logic [31:0] ra, rb;
      ro = 3'($urandom);
      ra = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
      rb = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
      if (ro[2:1] == 2'b01 && $urandom_range(0, 7) == 0) rb = 32'd0;
      if (ro == 3'd2 && ra == 32'h8000_0000 && rb == 32'hFFFF_FFFF) rb = 32'd1;
      if (!e_busy) lat_sel = $urandom_range(1, 40);
      if ($urandom_range(0, 199) == 0) reset_cycle();
      else drive($urandom_range(0, 9) < 6, ro, ra, rb);
    end

    idle(); idle();
    #5;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/muldiv_ctrl.md
# muldiv_ctrl

Issue and HI/LO control for the M1 CPU's multiply/divide path. The block accepts MULT/MULTU/DIV/DIVU/MFHI/MFLO/MTHI/MTLO from the execute stage. It drives the iterative multiplier and divider over their Alternating Bit Protocol (ABP) toggle handshake and captures their results into the architectural HI/LO registers. While a unit is in flight it stalls dependent instructions.

## Interface
- DIV0_BYPASS, 1: when 1, DIV/DIVU with b_i==0 completes without the divider and writes HI=a_i, LO=32'hFFFFFFFF.
- sys_clock_i  in  1  single clock; all state updates on the rising edge.
- sys_reset_i  in  1  reset, synchronous, active-high.
- op_valid_i  in  1  execute-stage strobe.
- op_i  in  3  operation: 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MFHI, 101 MFLO, 110 MTHI, 111 MTLO.
- a_i, b_i  in  32  rs / rt operands.
- stall_o  out  1  combinational; op not accepted this cycle.
- result_o  out  32  MFHI/MFLO read data (combinational from HI/LO).
- result_valid_o  out  1  op_valid_i & MF* & !stall_o.
- busy_o  out  1  a unit is in flight.
- hi_o, lo_o  out  32  architectural HI/LO.
- opnd_a_o, opnd_b_o  out  32  registered operands to the multiplier and divider; stable while busy.
- opnd_signed_o  out  1  registered; 1 for MULT/DIV.
- mul_req_o  out  1  multiplier ABP request level.
- mul_ack_i  in  1  multiplier ABP acknowledge level.
- mul_product_i  in  64  multiplier product.
- div_req_o  out  1  divider ABP request level.
- div_ack_i  in  1  divider ABP acknowledge level.
- div_quotient_i  in  32  divider quotient.
- div_remainder_i  in  32  divider remainder.

## Operation
- States:
  - IDLE: no unit in flight.
  - MUL_WAIT: multiplier in flight.
  - DIV_WAIT: divider in flight.
- busy_o = (state != IDLE).
- stall_o = op_valid_i & busy_o. All op classes stall while busy. No bypass and no overlap.
- An op is accepted on an edge where op_valid_i=1 and stall_o=0.
- IDLE, accept MULT/MULTU:
  - Latch a_i, b_i and the signed flag into the opnd registers.
  - Toggle mul_req_o.
  - Go to MUL_WAIT.
- IDLE, accept DIV/DIVU:
  - Same as MULT/MULTU, but toggle div_req_o and go to DIV_WAIT.
  - Exception: with DIV0_BYPASS=1 and b_i==0, write HI=a_i and LO=32'hFFFFFFFF. No request toggle; stay in IDLE.
- IDLE, accept MTHI/MTLO: write a_i into HI/LO at that edge.
- IDLE, MFHI/MFLO: result_o = HI/LO with result_valid_o=1 in the same cycle. No state change.
- MUL_WAIT: when mul_ack_i == mul_req_o, capture HI=mul_product_i[63:32] and LO=mul_product_i[31:0], then go to IDLE.
- DIV_WAIT: when div_ack_i == div_req_o, capture HI=div_remainder_i and LO=div_quotient_i, then go to IDLE.
  - Results are stored exactly as the units deliver them; there is no sign fix-up here.
- Ack levels are ignored in IDLE. An ack from the non-selected unit is ignored in any state.
- opnd_* are not modified while busy, because the units latch their operands one edge after the request toggle.
- result_o is don't-care when result_valid_o=0.

## Timing
- Reset values: state IDLE; mul_req_o=0, div_req_o=0; HI=0, LO=0; opnd_a_o=0, opnd_b_o=0, opnd_signed_o=0; stall_o and result_valid_o follow their equations.
- Reset mid-operation: state returns to IDLE and both req levels return to 0.
  - The units share sys_reset_i, so their acks return to 0 and the levels stay matched.
  - An in-flight result is discarded; HI/LO read 0.
- Request toggle is registered at the accept edge N.
- With the 32-step units, the unit latches at N+1 and acks at N+34. Capture happens at N+35 and busy_o is low from N+35.
- Completion must not depend on that count; it is detected purely by the level match.
- Capture cycle: busy_o is still 1 during the cycle before the capture edge. An op presented then stalls and is accepted on the first cycle after capture.
- MF* waiting behind a busy unit returns the new HI/LO in the first cycle after capture.
- The DIV0 bypass and MT* writes take effect at the accept edge and are visible on hi_o/lo_o in the next cycle.

## Test plan
- MULTU a=17, b=3 -> mul_req_o toggles 0->1; HI=0, LO=51 at N+35; div_req_o unchanged.
- MULT a=-7, b=3 -> HI=32'hFFFFFFFF, LO=32'hFFFFFFEB; opnd_signed_o=1 throughout.
- DIVU a=17, b=5 -> LO=3, HI=2. Then DIV a=20, b=4 -> LO=5, HI=0, and div_req_o toggles back to 0.
- MFLO issued one cycle after DIVU 17/5 and held -> stall_o=1 until capture; then result_valid_o=1 with result_o=3 in the following cycle only.
- DIVU a=9, b=0 (DIV0_BYPASS=1) -> HI=9, LO=32'hFFFFFFFF next cycle; div_req_o unchanged; busy_o never 1.
- MULTU, then sys_reset_i for 1 cycle at N+10 -> all outputs at reset values. Then MTHI a=0x1234 and MFHI -> result_o=0x1234. Then MULTU 6*7 -> LO=42 with normal latency.
